// File: rtl/qam_shaping_filter.sv
// I/Q pulse-shaping interpolator: QPSK/16-QAM level mapping, polyphase FIR per rail
// with a runtime-loadable coefficient RAM, saturated baseband and an fs/4 digital-IF output.
module qam_shaping_filter #(
  parameter int SPS    = 8,
  parameter int SPAN   = 16,
  parameter int COEF_W = 13,
  parameter int OUT_W  = 14,
  parameter int SHIFT  = 0,
  localparam int PW    = $clog2(SPS),
  localparam int NT    = SPAN + 1,
  localparam int AW    = $clog2(NT * SPS)
) (
  input  logic              clock_5000,
  input  logic              reset,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [1:0]        sym_i,
  input  logic [1:0]        sym_q,
  input  logic              mode,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [OUT_W-1:0]  base_i_out,
  output logic [OUT_W-1:0]  base_q_out,
  output logic [OUT_W-1:0]  if_out,
  output logic              out_valid,
  output logic              underrun
);

  localparam int PROD_W = COEF_W + 3;
  localparam int SUM_W  = PROD_W + $clog2(NT);
  localparam int TW     = AW - PW;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

  logic [PW-1:0]            phase;
  logic                     accepted;
  logic signed [2:0]        dl_i [NT];
  logic signed [2:0]        dl_q [NT];
  logic signed [COEF_W-1:0] coef_mem [NT*SPS];
  logic signed [PROD_W-1:0] prod_i_c [NT];
  logic signed [PROD_W-1:0] prod_q_c [NT];
  logic signed [PROD_W-1:0] prod_i_r [NT];
  logic signed [PROD_W-1:0] prod_q_r [NT];
  logic signed [SUM_W-1:0]  sum_i_c, sum_q_c, sum_i_r, sum_q_r;
  logic                     v_s1, v_s2;
  logic [1:0]               if_n;

  function automatic logic signed [2:0] map_level(input logic [1:0] b, input logic qam16);
    if (qam16) begin
      case (b)
        2'b00:   return 3'sd3;
        2'b01:   return 3'sd1;
        2'b10:   return -3'sd1;
        default: return -3'sd3;
      endcase
    end else begin
      return b[1] ? -3'sd3 : 3'sd3;
    end
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = s >>> SHIFT;
    if (sh > SAT_HI)      return OUT_W'(SAT_HI);
    else if (sh < SAT_LO) return OUT_W'(SAT_LO);
    else                  return OUT_W'(sh);
  endfunction

  // Most negative code has no positive twin, so it folds to full-scale positive.
  function automatic logic [OUT_W-1:0] neg_sat(input logic [OUT_W-1:0] x);
    if (x == {1'b1, {(OUT_W-1){1'b0}}}) return {1'b0, {(OUT_W-1){1'b1}}};
    else                                return -x;
  endfunction

  // Handshake: a symbol transfers on the rising edge where sym_valid and sym_ready are
  // both high; sym_ready is high only in the last phase of a symbol period and never
  // depends on sym_valid. Nothing is buffered, so a symbol offered at any other phase is ignored.
  assign sym_ready = (phase == PW'(SPS - 1));

  always_ff @(posedge clock_5000 or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      accepted <= 1'b0;
      underrun <= 1'b0;
      for (int k = 0; k < NT; k++) begin
        dl_i[k] <= '0;
        dl_q[k] <= '0;
      end
    end else begin
      phase <= phase + PW'(1);
      if (sym_ready) begin
        dl_i[0] <= sym_valid ? map_level(sym_i, mode) : 3'sd0;
        dl_q[0] <= sym_valid ? map_level(sym_q, mode) : 3'sd0;
        for (int k = 1; k < NT; k++) begin
          dl_i[k] <= dl_i[k-1];
          dl_q[k] <= dl_q[k-1];
        end
        if (sym_valid)     accepted <= 1'b1;
        else if (accepted) underrun <= 1'b1;
      end
    end
  end

  // Coefficient RAM keeps its contents across reset.
  always_ff @(posedge clock_5000) begin
    if (coef_we) coef_mem[coef_addr] <= coef_data;
  end

  for (genvar k = 0; k < NT; k++) begin : g_tap
    assign prod_i_c[k] = PROD_W'(dl_i[k]) * PROD_W'(coef_mem[{TW'(k), phase}]);
    assign prod_q_c[k] = PROD_W'(dl_q[k]) * PROD_W'(coef_mem[{TW'(k), phase}]);
  end

  always_comb begin
    sum_i_c = '0;
    sum_q_c = '0;
    for (int k = 0; k < NT; k++) begin
      sum_i_c = sum_i_c + SUM_W'(prod_i_r[k]);
      sum_q_c = sum_q_c + SUM_W'(prod_q_r[k]);
    end
  end

  always_ff @(posedge clock_5000 or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NT; k++) begin
        prod_i_r[k] <= '0;
        prod_q_r[k] <= '0;
      end
      sum_i_r    <= '0;
      sum_q_r    <= '0;
      base_i_out <= '0;
      base_q_out <= '0;
      if_out     <= '0;
      if_n       <= 2'd0;
      v_s1       <= 1'b0;
      v_s2       <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      prod_i_r   <= prod_i_c;
      prod_q_r   <= prod_q_c;
      sum_i_r    <= sum_i_c;
      sum_q_r    <= sum_q_c;
      base_i_out <= sat_out(sum_i_r);
      base_q_out <= sat_out(sum_q_r);
      v_s1       <= 1'b1;
      v_s2       <= v_s1;
      out_valid  <= v_s2;
      if_n       <= out_valid ? if_n + 2'd1 : 2'd0;
      case (if_n)
        2'd0:    if_out <= base_i_out;
        2'd1:    if_out <= neg_sat(base_q_out);
        2'd2:    if_out <= neg_sat(base_i_out);
        default: if_out <= base_q_out;
      endcase
    end
  end

endmodule
